// File: rtl/config_pkg.sv
// Shared encodings for the configuration-port arbiter: source identifiers
// (numerically ordered by priority) and arbiter FSM states.
package config_pkg;

  // Higher value means higher priority; SELF owns the port when nobody else does.
  typedef enum logic [1:0] {
    SRC_SELF    = 2'd0,
    SRC_BITBANG = 2'd1,
    SRC_UART    = 2'd2,
    SRC_JTAG    = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWITCH  = 2'd1,
    OWNED   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Guard counter width; covers GUARD_CYCLES up to 15.
  localparam int GUARD_W = 4;

endpackage

// File: rtl/config_prio_enc.sv
// Fixed-priority encoder: JTAG > UART > BITBANG. Returns the winning source
// encoding and whether any external source is requesting.
module config_prio_enc
  import config_pkg::*;
(
  input  logic       i_jtag,
  input  logic       i_uart,
  input  logic       i_bitbang,
  output logic [1:0] o_owner,
  output logic       o_valid
);

  // Pick the highest-priority active request.
  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    o_owner = SRC_SELF;
    if (i_jtag) begin
      o_owner = SRC_JTAG;
    end else if (i_uart) begin
      o_owner = SRC_UART;
    end else if (i_bitbang) begin
      o_owner = SRC_BITBANG;
    end
  end

  assign o_valid = i_jtag | i_uart | i_bitbang;

endmodule

// File: rtl/config_port_arbiter.sv
// Arbitrates ownership of the configuration write port between JTAG, UART,
// bit-bang and the local (SELF) source. Ownership changes pass through a
// guard interval and resynchronise the downstream config FSM.
module config_port_arbiter
  import config_pkg::*;
#(
  parameter int GUARD_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        jtag_active,
  input  logic        uart_active,
  input  logic        bitbang_active,
  input  logic [31:0] jtag_data,
  input  logic [31:0] uart_data,
  input  logic [31:0] bitbang_data,
  input  logic [31:0] self_data,
  input  logic        jtag_strobe,
  input  logic        uart_strobe,
  input  logic        bitbang_strobe,
  input  logic        self_strobe,
  output logic [31:0] ConfigWriteData,
  output logic        ConfigWriteStrobe,
  output logic        FSM_Reset,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] word_count,
  output logic        dropped
);

  // The counter counts down to zero, so GUARD_CYCLES cycles need a load of N-1.
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);

  state_e             r_state;
  state_e             w_next_state;
  src_e               r_owner;
  logic [GUARD_W-1:0] r_guard;
  logic [31:0]        r_wr_data;
  logic               r_wr_strobe;
  logic               r_fsm_reset;
  logic [15:0]        r_word_count;
  logic               r_dropped;

  logic [1:0]         w_prio_owner;
  logic               w_prio_valid;
  logic               w_owner_active;
  logic [3:0]         w_strobes;
  logic [3:0]         w_accept_mask;
  logic [31:0]        w_fwd_data;
  logic               w_fwd_strobe;
  logic               w_drop;
  logic               w_enter_switch;
  logic               w_enter_release;

  config_prio_enc u_prio_enc (
    .i_jtag    (jtag_active),
    .i_uart    (uart_active),
    .i_bitbang (bitbang_active),
    .o_owner   (w_prio_owner),
    .o_valid   (w_prio_valid)
  );

  // Strobe vector indexed by source encoding.
  assign w_strobes = {jtag_strobe, uart_strobe, bitbang_strobe, self_strobe};

  // Select the current owner's active flag and data word (owner is SELF in IDLE).
  always_comb begin
    w_owner_active = 1'b0;
    w_fwd_data     = self_data;
    case (r_owner)
      SRC_JTAG:    begin w_owner_active = jtag_active;    w_fwd_data = jtag_data;    end
      SRC_UART:    begin w_owner_active = uart_active;    w_fwd_data = uart_data;    end
      SRC_BITBANG: begin w_owner_active = bitbang_active; w_fwd_data = bitbang_data; end
      default:     begin w_owner_active = 1'b0;           w_fwd_data = self_data;    end
    endcase
  end

  // Only SELF in IDLE, or the owner in OWNED, may forward; every other strobe is discarded.
  always_comb begin
    w_accept_mask = '0;
    case (r_state)
      IDLE:    w_accept_mask[SRC_SELF] = 1'b1;
      OWNED:   w_accept_mask[r_owner]  = 1'b1;
      default: w_accept_mask = '0;
    endcase
  end

  assign w_fwd_strobe = |(w_strobes & w_accept_mask);
  assign w_drop       = |(w_strobes & ~w_accept_mask);

  // Next-state logic; no preemption while OWNED, priority re-evaluated at guard expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_prio_valid) w_next_state = SWITCH;
      SWITCH:  if (r_guard == '0) w_next_state = OWNED;
      OWNED:   if (!w_owner_active) w_next_state = RELEASE;
      RELEASE: if (r_guard == '0) w_next_state = w_prio_valid ? SWITCH : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_enter_switch  = (w_next_state == SWITCH) && (r_state != SWITCH);
  assign w_enter_release = (r_state == OWNED) && (w_next_state == RELEASE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Owner latch and guard counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_owner <= SRC_SELF;
      r_guard <= '0;
    end else begin
      if (w_enter_switch) begin
        r_owner <= src_e'(w_prio_owner);
      end else if (w_next_state == IDLE) begin
        r_owner <= SRC_SELF;
      end

      if (w_enter_switch || w_enter_release) begin
        r_guard <= GUARD_LOAD;
      end else if (r_guard != '0) begin
        r_guard <= r_guard - 1'b1;
      end
    end
  end

  // Registered forwarding, FSM resync pulse, word counter and sticky drop flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_data    <= '0;
      r_wr_strobe  <= 1'b0;
      r_fsm_reset  <= 1'b0;
      r_word_count <= '0;
      r_dropped    <= 1'b0;
    end else begin
      r_wr_strobe <= w_fwd_strobe;
      r_fsm_reset <= w_enter_switch;
      if (w_fwd_strobe) begin
        r_wr_data <= w_fwd_data;
      end

      if (w_enter_switch) begin
        r_word_count <= '0;
      end else if (w_fwd_strobe && (r_state == OWNED) && (r_word_count != 16'hFFFF)) begin
        r_word_count <= r_word_count + 16'd1;
      end

      if (w_drop) begin
        r_dropped <= 1'b1;
      end
    end
  end

  assign ConfigWriteData   = r_wr_data;
  assign ConfigWriteStrobe = r_wr_strobe;
  assign FSM_Reset         = r_fsm_reset;
  assign grant             = r_owner;
  assign busy              = (r_state != IDLE);
  assign word_count        = r_word_count;
  assign dropped           = r_dropped;

endmodule

// File: doc/config_port_arbiter.md
CONFIG_PORT_ARBITER -- requirements
Module: config_port_arbiter

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 4, meaning idle cycles inserted on every ownership change (legal range 1..15).
REQ-002 SHALL have port CLK  input  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have ports jtag_active, uart_active, bitbang_active  input  1 each  source requests ownership.
REQ-005 SHALL have ports jtag_data, uart_data, bitbang_data, self_data  input  32 each  source write words.
REQ-006 SHALL have ports jtag_strobe, uart_strobe, bitbang_strobe, self_strobe  input  1 each  single-cycle word-valid.
REQ-007 SHALL have port ConfigWriteData  output  32  forwarded word.
REQ-008 SHALL have port ConfigWriteStrobe  output  1  forwarded word-valid pulse.
REQ-009 SHALL have port FSM_Reset  output  1  one-cycle pulse resynchronising the downstream config FSM.
REQ-010 SHALL have port grant  output  2  current owner: 0 SELF, 1 BITBANG, 2 UART, 3 JTAG.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port word_count  output  16  words forwarded since last grant.
REQ-013 SHALL have port dropped  output  1  sticky: a strobe was discarded.

Function
REQ-014 SHALL implement states IDLE, SWITCH, OWNED, RELEASE.
REQ-015 IDLE: owner SELF; SHALL forward self_strobe/self_data; when any *_active high, SHALL latch highest-priority active source (JTAG > UART > BITBANG) and enter SWITCH.
REQ-016 SWITCH: SHALL pulse FSM_Reset in first cycle only, clear word_count, forward nothing, load guard counter, enter OWNED after exactly GUARD_CYCLES cycles.
REQ-017 OWNED: SHALL forward only the owner's strobe/data; SHALL NOT preempt when a higher-priority source activates; when owner's active deasserts, SHALL enter RELEASE.
REQ-018 RELEASE: SHALL forward nothing for GUARD_CYCLES cycles, then enter SWITCH if any *_active high (re-evaluating priority at that cycle), else IDLE.
REQ-019 Forwarding SHALL be registered: ConfigWriteStrobe/ConfigWriteData appear exactly 1 cycle after the accepted input strobe; ConfigWriteData SHALL hold its last value when strobe low.
REQ-020 word_count SHALL increment per forwarded strobe in OWNED, saturate at 16'hFFFF, clear in SWITCH; it SHALL NOT count SELF words in IDLE.
REQ-021 dropped SHALL set on any strobe from a non-owner, or any strobe during SWITCH/RELEASE; it SHALL clear only on reset.
REQ-022 A strobe coincident with owner's active falling SHALL be forwarded (decision uses registered state of current cycle).
REQ-023 Simultaneous activation of several sources in one cycle SHALL grant by fixed priority; losers wait, no strobe of theirs is forwarded.
REQ-024 grant SHALL show the latched owner from SWITCH entry until RELEASE exit; 0 in IDLE.

Reset
REQ-025 On reset: state IDLE, grant 0, ConfigWriteData 0, ConfigWriteStrobe 0, FSM_Reset 0, busy 0, word_count 0, dropped 0, guard counter 0.
REQ-026 Reset asserted mid-OWNED SHALL abort in the same cycle with no further forwarded strobe and no FSM_Reset pulse.

Structure
REQ-027 Source encoding constants (SRC_SELF..SRC_JTAG) and state encoding SHALL reside in shared package config_pkg.
REQ-028 One sub-module, config_prio_enc (3 requests -> 2-bit owner + valid), SHALL be natural; all else in one module.

Verification
REQ-029 Reset, self_strobe with 32'hDEADBEEF in IDLE -> ConfigWriteStrobe 1 cycle later, data 32'hDEADBEEF, word_count 0.
REQ-030 uart_active rises, 3 UART words after guard -> FSM_Reset one pulse, grant 2, 4 idle cycles, 3 strobes forwarded, word_count 3.
REQ-031 uart_active and jtag_active rise same cycle -> grant 3; UART strobes during JTAG ownership -> not forwarded, dropped 1.
REQ-032 UART owner, jtag_active rises mid-burst -> no preemption; UART drops active -> RELEASE 4 cycles, SWITCH, grant 3.
REQ-033 Strobe during SWITCH guard -> not forwarded, dropped 1; 70000 words in OWNED -> word_count 16'hFFFF.
REQ-034 reset asserted in OWNED with strobe same cycle -> no ConfigWriteStrobe next cycle, all outputs at reset values.
